control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle FSM control unit for the 19-bit CPU.
- Latches the 5-bit opcode, sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, and drives one-hot-style strobes to the PC, IR, register file, ALU, stack pointer and memory.
- Sits between the instruction register and the datapath.
- All bus signals are carried on control_bus_if; they are listed flattened below.

Parameters:
- OPCODE_W, 5, opcode width.
- FLAG_W, 4, flag vector width: bit0 Z, bit1 N, bit2 C, bit3 V.
- ALU_OP_W, 4, ALU operation select width.

Ports:
- CLK  in  1  clock, all logic on the rising edge.
- RST  in  1  reset, synchronous and active-high; overrides EN.
- EN  in  1  advance enable; 0 = stall (state held, strobes low).
- OPCODE  in  5  control_bus_if.OPCODE, current IR opcode.
- FLAGS  in  4  control_bus_if.FLAGS from the ALU status register.
- PC_INC  out  1  increment PC.
- PC_LOAD  out  1  load PC from target bus.
- IR_LOAD  out  1  load instruction register.
- MEM_RD  out  1  memory read strobe.
- MEM_WR  out  1  memory write strobe.
- REG_WE  out  1  register file write enable.
- ALU_OP  out  4  ALU op select.
- SP_INC  out  1  stack pointer +1.
- SP_DEC  out  1  stack pointer -1.
- ILLEGAL  out  1  unknown opcode detected.
- STATE  out  3  current state, for debug.

Behaviour:
- Opcodes, package encoding: NOP 00000, ADD 00001, SUB 00010, MUL 00011, DIV 00100, AND 00101, OR 00110, XOR 00111, NOT 01000, JMP 01001, BEQ 01010, BNE 01011, CALL 01100, RET 01101, LD 01110, ST 01111. All other codes are illegal.
- States: FETCH 0, DECODE 1, EXECUTE 2, MEMORY 3, WRITEBACK 4, HALT 5.
- Reset: state FETCH, latched opcode NOP. All outputs 0 in the cycle after RST is sampled high. RST mid-instruction aborts the instruction.
- EN=0: state and latched opcode held; all strobes 0; ALU_OP holds.
- FETCH: MEM_RD=1, IR_LOAD=1, PC_INC=1; next state DECODE.
- DECODE: latch OPCODE; no strobes; next state EXECUTE.
- EXECUTE:
  - ALU ops: ALU_OP = opcode[3:0]; next WRITEBACK.
  - NOP: next FETCH.
  - JMP: PC_LOAD=1; next FETCH.
  - BEQ: PC_LOAD = FLAGS[0], sampled this cycle; next FETCH.
  - BNE: PC_LOAD = ~FLAGS[0]; next FETCH.
  - CALL: SP_DEC=1; next MEMORY.
  - RET, LD, ST: next MEMORY.
- MEMORY:
  - CALL: MEM_WR=1 (push PC), PC_LOAD=1; next FETCH.
  - RET: MEM_RD=1, PC_LOAD=1, SP_INC=1; next FETCH.
  - LD: MEM_RD=1; next WRITEBACK.
  - ST: MEM_WR=1; next FETCH.
- WRITEBACK: REG_WE=1, ALU_OP held; next FETCH.
- Latencies: ALU op 4 cycles; LD 5; ST, CALL and RET 4; JMP, BEQ, BNE and NOP 3.
- Outputs are combinational from the registered state and latched opcode, so they are glitch-free relative to CLK. OPCODE changes outside DECODE are ignored.
- Illegal opcode: ILLEGAL=1 in EXECUTE; default handling is as NOP (next FETCH).

Optional Feature:
- Macro CU_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in EXECUTE asserts ILLEGAL and enters HALT. HALT holds ILLEGAL=1 with all other strobes 0 until RST.
- Undefined: HALT is unreachable; an illegal opcode pulses ILLEGAL for one cycle and returns to FETCH.

Decomposition:
- Package opcodes: opcode enum typedef (5-bit) and ALU_OP values.
- Package constants: state enum typedef, FLAG bit indices (Z_IDX=0), widths.
- control_bus_if bundles OPCODE, FLAGS and all outputs, with modport cu (CU drives strobes) and modport dp.
- One sub-module: cu_decoder, combinational map from (state, opcode, flags) to the strobe vector and next state. control_unit keeps the state and opcode registers.

Test Plan:
- RST=1 for 1 cycle, EN=1 -> STATE=0, all strobes 0; next cycle MEM_RD=IR_LOAD=PC_INC=1.
- OPCODE=ADD (00001) -> DECODE, then EXECUTE with ALU_OP=0001, then WRITEBACK with REG_WE=1, back to FETCH after 4 cycles.
- BEQ with FLAGS[0]=1 -> PC_LOAD=1 in EXECUTE. Repeat with FLAGS[0]=0 -> PC_LOAD=0. BNE with FLAGS[0]=0 -> PC_LOAD=1.
- CALL -> SP_DEC in EXECUTE, then MEM_WR+PC_LOAD. RET -> MEM_RD+PC_LOAD+SP_INC. LD -> MEM_RD then REG_WE. ST -> MEM_WR only.
- EN=0 during EXECUTE for 3 cycles -> STATE holds 2, strobes 0; resume finishes correctly. RST asserted in MEMORY -> FETCH next cycle.
- OPCODE=11111 -> ILLEGAL=1. With CU_ILLEGAL_TRAP_EN: STATE=5 held until RST. Without it: FETCH next cycle.

Source files
------------

// File: rtl/control_unit_pkg.sv
// ============================================================================
// Module      : control_unit_pkg
// Description : Shared types for the 19-bit CPU control unit: opcode and
//               state encodings, strobe bundle, flag indices and widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_unit_pkg;

    localparam int OPCODE_W = 5;
    localparam int FLAG_W   = 4;
    localparam int ALU_OP_W = 4;
    localparam int STATE_W  = 3;

    // Flag vector bit positions
    localparam int Z_IDX = 0;
    localparam int N_IDX = 1;
    localparam int C_IDX = 2;
    localparam int V_IDX = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 5'b00000,
        OP_ADD  = 5'b00001,
        OP_SUB  = 5'b00010,
        OP_MUL  = 5'b00011,
        OP_DIV  = 5'b00100,
        OP_AND  = 5'b00101,
        OP_OR   = 5'b00110,
        OP_XOR  = 5'b00111,
        OP_NOT  = 5'b01000,
        OP_JMP  = 5'b01001,
        OP_BEQ  = 5'b01010,
        OP_BNE  = 5'b01011,
        OP_CALL = 5'b01100,
        OP_RET  = 5'b01101,
        OP_LD   = 5'b01110,
        OP_ST   = 5'b01111
    } opcode_t;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    typedef struct packed {
        logic pc_inc;
        logic pc_load;
        logic ir_load;
        logic mem_rd;
        logic mem_wr;
        logic reg_we;
        logic sp_inc;
        logic sp_dec;
        logic illegal;
    } strobes_t;

    // ALU class opcodes run through WRITEBACK; their low nibble is the ALU select
    function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_decoder.sv
// ============================================================================
// Module      : cu_decoder
// Description : Combinational map from (state, latched opcode, Z flag) to the
//               datapath strobe bundle and the next FSM state.
//               Optional feature macro: CU_ILLEGAL_TRAP_EN (illegal -> HALT).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_decoder
    import control_unit_pkg::*;
(
    input  state_t                i_state,
    input  logic [OPCODE_W-1:0]   i_opcode,
    input  logic                  i_flag_z,
    output strobes_t              o_strobes,
    output state_t                o_next_state
);

    // Strobes and next state for the current step of the instruction
    always_comb begin
        o_strobes    = '0;
        o_next_state = i_state;
        case (i_state)
            ST_FETCH: begin
                o_strobes.mem_rd  = 1'b1;
                o_strobes.ir_load = 1'b1;
                o_strobes.pc_inc  = 1'b1;
                o_next_state      = ST_DECODE;
            end
            ST_DECODE: begin
                o_next_state = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                o_next_state = ST_FETCH;
                if (is_alu_op(i_opcode)) begin
                    o_next_state = ST_WRITEBACK;
                end else begin
                    case (i_opcode)
                        OP_NOP: ;
                        OP_JMP: o_strobes.pc_load = 1'b1;
                        OP_BEQ: o_strobes.pc_load = i_flag_z;
                        OP_BNE: o_strobes.pc_load = ~i_flag_z;
                        OP_CALL: begin
                            o_strobes.sp_dec = 1'b1;
                            o_next_state     = ST_MEMORY;
                        end
                        OP_RET, OP_LD, OP_ST: o_next_state = ST_MEMORY;
                        default: begin
                            o_strobes.illegal = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
                            o_next_state = ST_HALT;
`else
                            o_next_state = ST_FETCH;
`endif
                        end
                    endcase
                end
            end
            ST_MEMORY: begin
                o_next_state = ST_FETCH;
                case (i_opcode)
                    OP_CALL: begin
                        o_strobes.mem_wr  = 1'b1;
                        o_strobes.pc_load = 1'b1;
                    end
                    OP_RET: begin
                        o_strobes.mem_rd  = 1'b1;
                        o_strobes.pc_load = 1'b1;
                        o_strobes.sp_inc  = 1'b1;
                    end
                    OP_LD: begin
                        o_strobes.mem_rd = 1'b1;
                        o_next_state     = ST_WRITEBACK;
                    end
                    OP_ST: o_strobes.mem_wr = 1'b1;
                    default: ;
                endcase
            end
            ST_WRITEBACK: begin
                o_strobes.reg_we = 1'b1;
                o_next_state     = ST_FETCH;
            end
            ST_HALT: begin
                o_strobes.illegal = 1'b1;
                o_next_state      = ST_HALT;
            end
            default: o_next_state = ST_FETCH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer
//               for the 19-bit CPU. Holds the state and latched opcode and
//               gates the decoder strobes with EN and the post-reset cycle.
//               Optional feature macro: CU_ILLEGAL_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
    import control_unit_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [OPCODE_W-1:0]   OPCODE,
    input  logic [FLAG_W-1:0]     FLAGS,
    output logic                  PC_INC,
    output logic                  PC_LOAD,
    output logic                  IR_LOAD,
    output logic                  MEM_RD,
    output logic                  MEM_WR,
    output logic                  REG_WE,
    output logic [ALU_OP_W-1:0]   ALU_OP,
    output logic                  SP_INC,
    output logic                  SP_DEC,
    output logic                  ILLEGAL,
    output logic [STATE_W-1:0]    STATE
);

    state_t                r_state;
    logic [OPCODE_W-1:0]   r_opcode;
    logic                  r_fresh;     // first cycle after reset: outputs quiet, no advance
    logic [ALU_OP_W-1:0]   r_alu_last;
    state_t                w_next_state;
    strobes_t              w_dec;
    logic                  w_go;
    logic                  w_alu_active;
    logic                  w_unused_flags;

    // Only Z steers control flow; the remaining flags are not consulted here
    assign w_unused_flags = ^FLAGS[V_IDX:N_IDX];

    cu_decoder u_decoder (
        .i_state      (r_state),
        .i_opcode     (r_opcode),
        .i_flag_z     (FLAGS[Z_IDX]),
        .o_strobes    (w_dec),
        .o_next_state (w_next_state)
    );

    assign w_go         = EN & ~r_fresh;
    assign w_alu_active = is_alu_op(r_opcode) &&
                          ((r_state == ST_EXECUTE) || (r_state == ST_WRITEBACK));

    // State, opcode latch and ALU select hold register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_FETCH;
            r_opcode   <= OP_NOP;
            r_fresh    <= 1'b1;
            r_alu_last <= '0;
        end else begin
            r_fresh    <= 1'b0;
            r_alu_last <= ALU_OP;
            if (w_go) begin
                r_state <= w_next_state;
                if (r_state == ST_DECODE) begin
                    r_opcode <= OPCODE;
                end
            end
        end
    end

    // Strobes are suppressed while stalled; HALT keeps ILLEGAL up regardless
    always_comb begin
        PC_INC  = w_go & w_dec.pc_inc;
        PC_LOAD = w_go & w_dec.pc_load;
        IR_LOAD = w_go & w_dec.ir_load;
        MEM_RD  = w_go & w_dec.mem_rd;
        MEM_WR  = w_go & w_dec.mem_wr;
        REG_WE  = w_go & w_dec.reg_we;
        SP_INC  = w_go & w_dec.sp_inc;
        SP_DEC  = w_go & w_dec.sp_dec;
        ILLEGAL = (r_state == ST_HALT) | (w_go & w_dec.illegal);
        ALU_OP  = w_alu_active ? r_opcode[ALU_OP_W-1:0] : r_alu_last;
        STATE   = r_state;
    end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module      : tb_control_unit
// Description : Self-checking bench for control_unit: directed literal checks
//               followed by randomized stimulus against an instruction-level
//               reference model. Honours CU_ILLEGAL_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b0;
    logic [4:0] OPCODE = 5'd0;
    logic [3:0] FLAGS = 4'd0;
    logic PC_INC, PC_LOAD, IR_LOAD, MEM_RD, MEM_WR, REG_WE, SP_INC, SP_DEC, ILLEGAL;
    logic [3:0] ALU_OP;
    logic [2:0] STATE;

    control_unit dut (
        .CLK(CLK), .RST(RST), .EN(EN), .OPCODE(OPCODE), .FLAGS(FLAGS),
        .PC_INC(PC_INC), .PC_LOAD(PC_LOAD), .IR_LOAD(IR_LOAD),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .REG_WE(REG_WE), .ALU_OP(ALU_OP),
        .SP_INC(SP_INC), .SP_DEC(SP_DEC), .ILLEGAL(ILLEGAL), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    // Strobe bit masks in the order {PC_INC,PC_LOAD,IR_LOAD,MEM_RD,MEM_WR,REG_WE,SP_INC,SP_DEC,ILLEGAL}
    localparam logic [8:0] S_PCI = 9'h100, S_PCL = 9'h080, S_IRL = 9'h040,
                           S_MRD = 9'h020, S_MWR = 9'h010, S_RWE = 9'h008,
                           S_SPI = 9'h004, S_SPD = 9'h002, S_ILL = 9'h001;
`ifdef CU_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    wire [8:0] strobes = {PC_INC, PC_LOAD, IR_LOAD, MEM_RD, MEM_WR, REG_WE, SP_INC, SP_DEC, ILLEGAL};

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    // Each instruction is a fixed list of steps; phase indexes into it.
    bit       m_valid = 0, m_fresh = 0, m_halt = 0;
    int       m_phase = 0;
    bit [4:0] m_op = 0;
    bit [3:0] m_alu = 0, m_exp_alu = 0;

    function automatic bit f_alu(input bit [4:0] op);
        return op >= 5'd1 && op <= 5'd8;
    endfunction

    function automatic int inst_len(input bit [4:0] op);
        if (f_alu(op)) return 4;
        if (op == 5'd14) return 5;               // LD
        if (op >= 5'd12 && op <= 5'd15) return 4; // CALL RET ST
        return 3;                                 // NOP JMP BEQ BNE illegal
    endfunction

    task automatic exp_step(input bit [4:0] op, input int ph, input bit z,
                            output bit [2:0] st, output bit [8:0] sb);
        sb = 9'h0;
        case (ph)
            0: begin st = 3'd0; sb = S_PCI | S_IRL | S_MRD; end
            1: st = 3'd1;
            2: begin
                st = 3'd2;
                case (op)
                    5'd9:  sb = S_PCL;
                    5'd10: sb = z ? S_PCL : 9'h0;
                    5'd11: sb = z ? 9'h0 : S_PCL;
                    5'd12: sb = S_SPD;
                    default: sb = (op >= 5'd16) ? S_ILL : 9'h0;
                endcase
            end
            3: begin
                if (f_alu(op)) begin st = 3'd4; sb = S_RWE; end
                else begin
                    st = 3'd3;
                    case (op)
                        5'd12: sb = S_MWR | S_PCL;
                        5'd13: sb = S_MRD | S_PCL | S_SPI;
                        5'd14: sb = S_MRD;
                        default: sb = S_MWR;
                    endcase
                end
            end
            default: begin st = 3'd4; sb = S_RWE; end
        endcase
    endtask

    // Compare process: check every cycle once the model has seen a reset
    always @(negedge CLK) begin
        bit [2:0] st;
        bit [8:0] sb;
        if (m_valid) begin
            if (m_halt) begin
                st = 3'd5; sb = S_ILL;
            end else if (m_fresh) begin
                st = 3'd0; sb = 9'h0;
            end else begin
                exp_step(m_op, m_phase, FLAGS[0], st, sb);
                if (!EN) sb = 9'h0;
            end
            m_exp_alu = (!m_fresh && !m_halt && f_alu(m_op) && (m_phase == 2 || m_phase == 3))
                        ? m_op[3:0] : m_alu;
            chk("state", int'(STATE), int'(st));
            chk("strobes", int'(strobes), int'(sb));
            chk("alu_op", int'(ALU_OP), int'(m_exp_alu));
        end
    end

    // Model advance on each rising edge
    always @(posedge CLK) begin
        if (RST) begin
            m_valid = 1; m_fresh = 1; m_halt = 0; m_phase = 0; m_op = 0; m_alu = 0;
        end else if (m_valid) begin
            m_alu = m_exp_alu;
            if (m_fresh) m_fresh = 0;
            else if (!m_halt && EN) begin
                if (m_phase == 1) m_op = OPCODE;
                if (m_phase == 2 && m_op >= 5'd16 && TRAP) m_halt = 1;
                else begin
                    m_phase++;
                    if (m_phase >= inst_len(m_op)) m_phase = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit rst, input bit en, input bit [4:0] op, input bit [3:0] fl);
        @(posedge CLK);
        #1;
        RST = rst; EN = en; OPCODE = op; FLAGS = fl;
        @(negedge CLK);
        #1;
    endtask

    initial begin
        bit [4:0] op;
        // Reset and first fetch
        step(1, 1, 5'd0, 4'h0);
        step(0, 1, 5'd1, 4'h0);
        chk("lit_reset_state", int'(STATE), 0);
        chk("lit_reset_strobes", int'(strobes), 0);
        step(0, 1, 5'd1, 4'h0);
        chk("lit_fetch", int'({MEM_RD, IR_LOAD, PC_INC}), 7);
        // ADD: decode latches 00001, opcode bus changed afterwards is ignored
        step(0, 1, 5'd1, 4'h0);
        chk("lit_decode_state", int'(STATE), 1);
        step(0, 1, 5'd31, 4'h0);
        chk("lit_add_exec", int'({STATE, ALU_OP}), {3'd2, 4'b0001});
        step(0, 1, 5'd0, 4'h0);
        chk("lit_add_wb", int'({STATE, REG_WE}), {3'd4, 1'b1});
        // BEQ taken, BEQ not taken, BNE taken
        step(0, 1, 5'd10, 4'h1); step(0, 1, 5'd10, 4'h1); step(0, 1, 5'd0, 4'h1);
        chk("lit_beq_taken", int'(PC_LOAD), 1);
        step(0, 1, 5'd10, 4'h0); step(0, 1, 5'd10, 4'h0); step(0, 1, 5'd0, 4'h0);
        chk("lit_beq_not", int'(PC_LOAD), 0);
        step(0, 1, 5'd11, 4'h0); step(0, 1, 5'd11, 4'h0); step(0, 1, 5'd0, 4'h0);
        chk("lit_bne_taken", int'(PC_LOAD), 1);
        // ADD with a 3-cycle stall in EXECUTE
        step(0, 1, 5'd1, 4'h0); step(0, 1, 5'd1, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 5'd0, 4'h0);
            chk("lit_stall", int'({STATE, strobes}), {3'd2, 9'h0});
        end
        step(0, 1, 5'd0, 4'h0);
        step(0, 1, 5'd0, 4'h0);
        chk("lit_stall_resume_wb", int'({STATE, REG_WE}), {3'd4, 1'b1});
        // ST aborted by reset in MEMORY
        step(0, 1, 5'd15, 4'h0); step(0, 1, 5'd15, 4'h0); step(0, 1, 5'd0, 4'h0);
        step(1, 1, 5'd0, 4'h0);
        chk("lit_st_mem", int'(STATE), 3);
        step(0, 1, 5'd0, 4'h0);
        chk("lit_abort_fetch", int'(STATE), 0);
        // Illegal opcode
        step(0, 1, 5'd31, 4'h0); step(0, 1, 5'd31, 4'h0); step(0, 1, 5'd0, 4'h0);
        chk("lit_illegal", int'(ILLEGAL), 1);
        step(0, 1, 5'd0, 4'h0);
        chk("lit_after_illegal", int'(STATE), TRAP ? 5 : 0);
        step(1, 1, 5'd0, 4'h0);
        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), op, 4'($urandom_range(0, 15)));
        end
        @(posedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
